// File: rtl/add_sub_sequencer.sv
// add_sub_sequencer
//   Multi-cycle WIDTH-bit add/subtract built from one SLICE-bit adder slice
//   reused over NSLICE cycles, least-significant slice first. The carry is
//   registered between slices. Produces the result plus {N,Z,C,V} flags
//   behind a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   RUN   | one slice per cycle, idx counts 0..NSLICE-1
//   DONE  | result/flags valid, held until out_ready
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (op_sub, a, b sampled on accept)
//   op_sub             0 = a+b, 1 = a-b
//   out_valid/out_ready result handshake
//   result             WIDTH-bit sum/difference (modulo 2^WIDTH)
//   flags              {N,Z,C,V}
module add_sub_sequencer #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [IDXW-1:0]   idx;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;       // already inverted for subtraction
  logic [WIDTH-1:0]  result_reg;
  logic [3:0]        flags_reg;

  logic [SLICE:0]    slice_sum;
  logic [WIDTH-1:0]  result_nxt;
  logic              accept;
  logic              last_slice;

  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == IDXW'(NSLICE - 1));

  // Shared adder slice
  always_comb begin
    slice_sum = {1'b0, a_reg[idx*SLICE +: SLICE]}
              + {1'b0, b_reg[idx*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry_reg};
  end

  // Result with the current slice merged in; flags are derived from this on
  // the final slice so they are ready the same edge DONE is entered.
  always_comb begin
    result_nxt = result_reg;
    result_nxt[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      carry_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      if (accept) begin
        a_reg      <= a;
        b_reg      <= op_sub ? ~b : b;
        carry_reg  <= op_sub;
        idx        <= '0;
        result_reg <= '0;
      end else if (state == RUN) begin
        result_reg <= result_nxt;
        carry_reg  <= slice_sum[SLICE];
        idx        <= idx + IDXW'(1);
        if (last_slice) begin
          flags_reg <= {result_nxt[WIDTH-1],
                        (result_nxt == '0),
                        slice_sum[SLICE],
                        (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (result_nxt[WIDTH-1] != a_reg[WIDTH-1])};
        end
      end
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;

endmodule

// File: tb/tb_add_sub_sequencer.sv
module tb_add_sub_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  add_sub_sequencer #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] va;
    logic [63:0] vb;
    logic        vsub;
    logic [63:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for out_valid; returns cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] va, input logic [63:0] vb,
                        input logic vsub, input logic [63:0] er, input logic [3:0] ef);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    a = va; b = vb; op_sub = vsub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk({name, " latency"}, 64'(n), 64'd4);
    chk({name, " result"}, result, er);
    chk({name, " flags"}, 64'(flags), 64'(ef));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, " out_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] held;
    logic seen;

    vecs[0] = '{"add_ovf_all",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0,                   4'b0110};
    vecs[1] = '{"add_signovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[2] = '{"sub_borrow",   64'd5,                   64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[3] = '{"sub_equal",    64'd7,                   64'd7, 1'b1, 64'd0,                   4'b0110};
    vecs[4] = '{"add_chain32",  64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    vecs[5] = '{"sub_minneg",   64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[6] = '{"add_small",    64'd2,                   64'd3, 1'b0, 64'd5,                   4'b0000};

    reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    step(); step();
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst flags", 64'(flags), 64'd0);

    // Reset and in_valid together: reset wins
    in_valid = 1'b1; a = 64'd9; b = 64'd9;
    step();
    chk("rst_vs_valid in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].exp_res, vecs[i].exp_flags);

    // Inputs toggled during RUN must not matter
    a = 64'h0000_0000_FFFF_FFFF; b = 64'd1; op_sub = 1'b0; in_valid = 1'b1;
    step();
    step();
    a = '0; b = 64'hDEAD_BEEF_0000_1234; op_sub = 1'b1;
    chk("toggle in_ready", 64'(in_ready), 64'd0);
    wait_out(n);
    chk("toggle latency", 64'(n), 64'd3);
    chk("toggle result", result, 64'h0000_0001_0000_0000);
    chk("toggle flags", 64'(flags), 64'd0);

    // Backpressure with a pending request
    held = result;
    a = 64'd10; b = 64'd20; op_sub = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp result", result, held);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("reaccept in_ready", 64'(in_ready), 64'd0);
    wait_out(n);
    chk("reaccept latency", 64'(n), 64'd4);
    chk("reaccept result", result, 64'd30);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during the second RUN cycle
    a = 64'd100; b = 64'd1; op_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort result", result, 64'd0);
    chk("abort flags", 64'(flags), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("abort no_out", 64'(seen), 64'd0);
    run_op("post_abort", 64'd2, 64'd3, 1'b0, 64'd5, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
